bcd_scan_display: RTL and testbench

- Parametrised successor to the team's single-digit 7-segment decoder.
- Accepts a binary value, converts it to BCD sequentially (shift-add-3, one bit per cycle) and drives DIGITS common-anode displays by time-multiplexing.
- Supports optional leading-zero blanking and an overflow indication.
- Sits between datapath result registers and the board's segment/anode pins.

---
 rtl/bcd_scan_display.sv | 174 +++++++++++++++++
 tb/tb_bcd_scan_display.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Binary-to-BCD converter (shift-add-3, one bit per cycle) driving a
// time-multiplexed common-anode 7-segment display with leading-zero blanking.
module bcd_scan_display #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned WIDTH         = 14,
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              overflow
);

  // Decimal digits needed to hold the largest WIDTH-bit value.
  function automatic int unsigned dec_digits(input int unsigned w);
    longint unsigned m;
    int unsigned     n;
    m = (64'd1 << w) - 64'd1;
    n = 0;
    do begin
      n++;
      m = m / 64'd10;
    end while (m != 64'd0);
    return n;
  endfunction

  localparam int unsigned NIB_W = dec_digits(WIDTH);
  localparam int unsigned BCD_N = (NIB_W > DIGITS) ? NIB_W : DIGITS;
  localparam int unsigned BW    = 4 * BCD_N;
  localparam int unsigned CW    = $clog2(WIDTH + 1);
  localparam int unsigned PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0011000;
      default: return SEG_BLANK;
    endcase
  endfunction

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [BW-1:0]          bcd_q, bcd_d;
  logic [BW-1:0]          bcd_adj;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DIGITS-1:0][3:0] disp_q, disp_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  logic                   blank;

  // Conversion FSM: capture, WIDTH shift-add-3 steps, then publish.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    bcd_adj = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d = value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        for (int i = 0; i < int'(BCD_N); i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, shift_d} = (BW + WIDTH)'({bcd_adj, shift_q} << 1);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        for (int i = 0; i < int'(DIGITS); i++) disp_d[i] = bcd_q[4*i +: 4];
        // Any non-zero nibble above the display width means the value does not fit.
        ovf_d = 1'b0;
        for (int i = int'(DIGITS); i < int'(BCD_N); i++) begin
          if (bcd_q[4*i +: 4] != 4'd0) ovf_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Free-running digit scan, independent of the converter.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Segment selection: overflow dash, then leading blank, then the digit.
  always_comb begin
    blank = (BLANK_LEADING != 0) && (idx_q != '0);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if ((IW'(i) >= idx_q) && (disp_q[i] != 4'd0)) blank = 1'b0;
    end
    if (ovf_q)      seg_d = SEG_DASH;
    else if (blank) seg_d = SEG_BLANK;
    else            seg_d = seg_of(disp_q[idx_q]);
    an_d = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= ~DIGITS'(1);
      seg_q   <= SEG_ZERO;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: three instances cover blanking on/off
// and the 8-digit, 27-bit, every-cycle-scan configuration.
module tb_bcd_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] value_ab;
  logic        load_ab;
  logic [26:0] value_c;
  logic        load_c;

  logic [6:0] seg_a, seg_b, seg_c;
  logic [3:0] an_a, an_b;
  logic [7:0] an_c;
  logic       busy_a, busy_b, busy_c;
  logic       ovf_a, ovf_b, ovf_c;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0011000, SB = 7'b1111111, SD = 7'b0111111;

  always #5 clk = ~clk;

  bcd_scan_display #(.DIGITS(4), .WIDTH(14), .REFRESH_DIV(4), .BLANK_LEADING(1)) u_a (
    .clk(clk), .rst_n(rst_n), .value(value_ab), .load(load_ab),
    .seg(seg_a), .an(an_a), .busy(busy_a), .overflow(ovf_a));

  bcd_scan_display #(.DIGITS(4), .WIDTH(14), .REFRESH_DIV(4), .BLANK_LEADING(0)) u_b (
    .clk(clk), .rst_n(rst_n), .value(value_ab), .load(load_ab),
    .seg(seg_b), .an(an_b), .busy(busy_b), .overflow(ovf_b));

  bcd_scan_display #(.DIGITS(8), .WIDTH(27), .REFRESH_DIV(1), .BLANK_LEADING(1)) u_c (
    .clk(clk), .rst_n(rst_n), .value(value_c), .load(load_c),
    .seg(seg_c), .an(an_c), .busy(busy_c), .overflow(ovf_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the selected instance to enable digit anv, then checks its segments.
  task automatic chk_digit(input string tag, input int sel, input logic [7:0] anv,
                           input logic [6:0] segv);
    logic [7:0] a;
    logic [6:0] s;
    a = '0;
    s = '0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      case (sel)
        0:       begin a = 8'(an_a); s = seg_a; end
        1:       begin a = 8'(an_b); s = seg_b; end
        default: begin a = an_c;     s = seg_c; end
      endcase
      if (a === anv) break;
    end
    check({tag, "_an"}, 32'(a), 32'(anv));
    check({tag, "_seg"}, 32'(s), 32'(segv));
  endtask

  // Load on instances a/b; leaves time 1ns after the capturing edge.
  task automatic load_ab_val(input logic [13:0] v);
    @(negedge clk);
    value_ab = v;
    load_ab  = 1'b1;
    @(posedge clk);
    #1;
    load_ab = 1'b0;
  endtask

  // Full conversion on a/b: busy high for 15 cycles, then one more for the pins.
  task automatic conv_ab(input string tag, input logic [13:0] v);
    load_ab_val(v);
    check({tag, "_busy_start"}, 32'(busy_a), 32'd1);
    step(14);
    check({tag, "_busy_last"}, 32'(busy_a), 32'd1);
    step(1);
    check({tag, "_busy_end"}, 32'(busy_a), 32'd0);
    step(1);
  endtask

  initial begin
    rst_n    = 1'b0;
    value_ab = '0;
    load_ab  = 1'b0;
    value_c  = '0;
    load_c   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an_a), 32'hE);
    check("rst_seg", 32'(seg_a), 32'(S0));
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_an_c", 32'(an_c), 32'hFE);
    @(negedge clk);
    rst_n = 1'b1;

    // Scan after reset: index moves every 4 clocks, pins lag by one.
    step(1);  check("scan_e1_an", 32'(an_a), 32'hE);
    step(3);  check("scan_e4_an", 32'(an_a), 32'hE);
    check("scan_e4_seg", 32'(seg_a), 32'(S0));
    step(1);  check("scan_e5_an", 32'(an_a), 32'hD);
    check("scan_e5_seg", 32'(seg_a), 32'(SB));
    step(4);  check("scan_e9_an", 32'(an_a), 32'hB);
    step(4);  check("scan_e13_an", 32'(an_a), 32'h7);
    check("scan_e13_seg", 32'(seg_a), 32'(SB));
    step(4);  check("scan_e17_an", 32'(an_a), 32'hE);
    check("scan_e17_seg", 32'(seg_a), 32'(S0));
    check("scan_busy", 32'(busy_a), 32'd0);

    // 1234
    conv_ab("v1234", 14'd1234);
    check("v1234_ovf", 32'(ovf_a), 32'd0);
    chk_digit("v1234_d0", 0, 8'h0E, S4);
    chk_digit("v1234_d1", 0, 8'h0D, S3);
    chk_digit("v1234_d2", 0, 8'h0B, S2);
    chk_digit("v1234_d3", 0, 8'h07, S1);

    // 7 with and without leading blanking
    conv_ab("v7", 14'd7);
    chk_digit("v7_a_d0", 0, 8'h0E, S7);
    chk_digit("v7_a_d1", 0, 8'h0D, SB);
    chk_digit("v7_a_d3", 0, 8'h07, SB);
    chk_digit("v7_b_d0", 1, 8'h0E, S7);
    chk_digit("v7_b_d1", 1, 8'h0D, S0);
    chk_digit("v7_b_d3", 1, 8'h07, S0);

    // 9999 fits; 10000 overflows; 0 clears
    conv_ab("v9999", 14'd9999);
    check("v9999_ovf", 32'(ovf_a), 32'd0);
    chk_digit("v9999_d0", 0, 8'h0E, S9);
    chk_digit("v9999_d3", 0, 8'h07, S9);
    conv_ab("v10000", 14'd10000);
    check("v10000_ovf", 32'(ovf_a), 32'd1);
    chk_digit("v10000_d0", 0, 8'h0E, SD);
    chk_digit("v10000_d3", 0, 8'h07, SD);
    chk_digit("v10000_b_d2", 1, 8'h0B, SD);
    conv_ab("v0", 14'd0);
    check("v0_ovf", 32'(ovf_a), 32'd0);
    chk_digit("v0_d0", 0, 8'h0E, S0);
    chk_digit("v0_d2", 0, 8'h0B, SB);

    // load while busy is dropped; busy timing is unaffected
    load_ab_val(14'd1234);
    step(2);
    load_ab_val(14'd5678);
    check("ign_busy", 32'(busy_a), 32'd1);
    step(11);
    check("ign_busy_last", 32'(busy_a), 32'd1);
    step(1);
    check("ign_busy_end", 32'(busy_a), 32'd0);
    step(1);
    chk_digit("ign_d0", 0, 8'h0E, S4);
    chk_digit("ign_d1", 0, 8'h0D, S3);
    chk_digit("ign_d3", 0, 8'h07, S1);

    // Reset in the middle of a conversion
    load_ab_val(14'd5678);
    step(5);
    check("mid_busy_pre", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an_a), 32'hE);
    check("mid_rst_seg", 32'(seg_a), 32'(S0));
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_ovf", 32'(ovf_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(20);
    check("mid_after_busy", 32'(busy_a), 32'd0);
    chk_digit("mid_d0", 0, 8'h0E, S0);
    chk_digit("mid_d1", 0, 8'h0D, SB);
    chk_digit("mid_d3", 0, 8'h07, SB);

    // 8 digits, 27 bits, scan every cycle
    @(negedge clk);
    value_c = 27'd87654321;
    load_c  = 1'b1;
    @(posedge clk);
    #1;
    load_c = 1'b0;
    check("c_busy_start", 32'(busy_c), 32'd1);
    step(27);
    check("c_busy_last", 32'(busy_c), 32'd1);
    step(1);
    check("c_busy_end", 32'(busy_c), 32'd0);
    step(1);
    chk_digit("c_d0", 2, 8'hFE, S1);
    @(negedge clk);
    check("c_scan_next", 32'(an_c), 32'hFD);
    check("c_scan_next_seg", 32'(seg_c), 32'(S2));
    chk_digit("c_d2", 2, 8'hFB, S3);
    chk_digit("c_d3", 2, 8'hF7, S4);
    chk_digit("c_d4", 2, 8'hEF, S5);
    chk_digit("c_d5", 2, 8'hDF, S6);
    chk_digit("c_d6", 2, 8'hBF, S7);
    chk_digit("c_d7", 2, 8'h7F, S8);
    check("c_ovf", 32'(ovf_c), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
